// File: rtl/fft_pkg.sv
// Shared FFT definitions: transform size, sample type, unloader states and the
// bank-steering helpers used by both the load and unload sides.
package fft_pkg;

   localparam int N_LOG2 = 6;
   localparam int DW     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } unload_state_e;

   typedef struct packed {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } sample_t;

   // Reverse the low n bits of v; bits at and above n come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < n) r[i] = v[n-1-i];
      end
      return r;
   endfunction

   // Bank select for a storage position: bank = XOR of all position bits.
   function automatic logic parity(input logic [31:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry fall-through FIFO of {data, index, last}; when empty, a push is
// visible at the head in the same cycle so the SRAM data can leave immediately.
module fft_out_skid #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic [IDX_W-1:0]  push_index_i,
   input  logic              push_last_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_data_o,
   output logic [IDX_W-1:0]  head_index_o,
   output logic              head_last_o,
   output logic [1:0]        count_o,
   output logic              full_o,
   output logic              empty_o
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [IDX_W-1:0]  index;
      logic              last;
   } entry_t;

   entry_t     mem_q [2];
   entry_t     push_entry;
   entry_t     head_entry;
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic [1:0] count_q, count_d;
   logic       store;
   logic       deq;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;

   always_comb begin
      push_entry = {push_data_i, push_index_i, push_last_i};
      // A push that is popped while the FIFO is empty bypasses storage entirely.
      store      = push_i & ~(empty_o & pop_i);
      deq        = pop_i & ~empty_o;
      wr_ptr_d   = wr_ptr_q ^ store;
      rd_ptr_d   = rd_ptr_q ^ deq;
      count_d    = count_q + {1'b0, store} - {1'b0, deq};
      head_entry = '0;
      if (!empty_o)    head_entry = mem_q[rd_ptr_q];
      else if (push_i) head_entry = push_entry;
   end

   assign head_data_o  = head_entry.data;
   assign head_index_o = head_entry.index;
   assign head_last_o  = head_entry.last;

   // NOTE: reset is synchronous, so it sits inside the clocked branch and nrst is not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the head is forced to zero whenever nothing valid is there.
   always_ff @(posedge clk) begin
      if (store) mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/fft_output_reorder.sv
// Frame unloader: reads the in-place FFT result from two SRAM banks and streams it
// out over valid/ready. Define FFT_OUT_REORDER_EN for natural (bit-reversal undone) order.
module fft_output_reorder #(
   parameter int N_LOG2 = fft_pkg::N_LOG2,
   parameter int DW     = fft_pkg::DW
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                start,
   output logic                re_b0,
   output logic                re_b1,
   output logic [N_LOG2-2:0]   raddr_b0,
   output logic [N_LOG2-2:0]   raddr_b1,
   input  logic [2*DW-1:0]     rdata_b0,
   input  logic [2*DW-1:0]     rdata_b1,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*DW-1:0]     out_data,
   output logic [N_LOG2-1:0]   out_index,
   output logic                out_last,
   output logic                busy,
   output logic                done
);
   import fft_pkg::*;

   localparam int AW = N_LOG2 - 1;

   unload_state_e     state_q, state_d;
   logic [N_LOG2-1:0] k_q;
   logic              inflight_q;
   logic              rd_bank_q;
   logic [N_LOG2-1:0] rd_index_q;
   logic              rd_last_q;
   logic              done_q;

   logic [N_LOG2-1:0] pos;
   logic [N_LOG2-1:0] index;
   logic              bank;
   logic [AW-1:0]     addr;
   logic              k_is_last;
   logic [1:0]        fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [2:0]        occupancy;
   logic              issue;
   logic              pop;
   logic [2*DW-1:0]   push_data;

   // Read address generation for frequency index k.
   always_comb begin
`ifdef FFT_OUT_REORDER_EN
      pos   = N_LOG2'(bitrev(32'(k_q), N_LOG2));
      index = k_q;
`else
      pos   = k_q;
      index = N_LOG2'(bitrev(32'(k_q), N_LOG2));
`endif
      bank      = parity(32'(pos));
      addr      = pos[N_LOG2-1:1];
      k_is_last = (k_q == {N_LOG2{1'b1}});
   end

   // A new read is allowed only if the FIFO can still hold it when its data returns.
   always_comb begin
      pop       = out_valid & out_ready;
      occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
      issue     = (state_q == STREAM) && (occupancy <= 3'd1);
   end

   always_ff @(posedge clk) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = STREAM;
         STREAM:  if (issue && k_is_last) state_d = DRAIN;
         DRAIN:   if (pop && out_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      re_b0    = 1'b0;
      re_b1    = 1'b0;
      raddr_b0 = '0;
      raddr_b1 = '0;
      busy     = (state_q != IDLE);
      if (issue) begin
         if (bank) begin
            re_b1    = 1'b1;
            raddr_b1 = addr;
         end else begin
            re_b0    = 1'b1;
            raddr_b0 = addr;
         end
      end
   end

   // Tags for the read in flight travel alongside it and meet its data one cycle later.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         k_q        <= '0;
         inflight_q <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_index_q <= '0;
         rd_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         if (state_q == IDLE) k_q <= '0;
         else if (issue)      k_q <= k_q + 1'b1;
         inflight_q <= issue;
         rd_bank_q  <= bank;
         rd_index_q <= index;
         rd_last_q  <= k_is_last;
         done_q     <= (state_q == DRAIN) && pop && out_last;
      end
   end

   assign push_data = rd_bank_q ? rdata_b1 : rdata_b0;

   fft_out_skid #(
      .DATA_W (2*DW),
      .IDX_W  (N_LOG2)
   ) u_skid (
      .clk          (clk),
      .nrst         (nrst),
      .push_i       (inflight_q),
      .push_data_i  (push_data),
      .push_index_i (rd_index_q),
      .push_last_i  (rd_last_q),
      .pop_i        (pop),
      .head_data_o  (out_data),
      .head_index_o (out_index),
      .head_last_o  (out_last),
      .count_o      (fifo_count),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   assign out_valid = ~fifo_empty | inflight_q;
   assign done      = done_q;

   a_no_overflow : assert property (@(posedge clk) disable iff (!nrst)
      !(fifo_full && inflight_q && !pop));

endmodule
